// File: rtl/daq_pkg.sv
// daq_pkg
//   Shared definitions for the DAQ frame builder: frame marker words,
//   header/trailer tags, crcgen control codes, the readout FSM state type
//   and a small ceiling-divide helper used to size the layer slicer.
//   No ports (package).

package daq_pkg;

    // Frame marker words (19 bits, bit 18 set only on the idle word)
    localparam logic [18:0] IDLE_WORD  = 19'h40000;
    localparam logic [18:0] HDR_MARKER = 19'h0DB0A;
    localparam logic [18:0] TRL_MARKER = 19'h0DE0D;
    localparam logic [18:0] LYZ_WORD   = 19'h01000;
    localparam logic [18:0] TBZ_WORD   = 19'h02000;
    localparam logic [18:0] PAD_WORD   = 19'h03000;

    // Tags prefixed to header fields and to the final trailer word
    localparam logic [6:0]  HDR_TAG = 7'h0D;
    localparam logic [6:0]  FMT_TAG = 7'h00;
    localparam logic [7:0]  TRL_TAG = 8'b00111010;

    // crcgen control codes
    localparam logic [2:0]  CRC_OFF  = 3'd0;
    localparam logic [2:0]  CRC_BODY = 3'd1;
    localparam logic [2:0]  CRC_T1   = 3'd2;
    localparam logic [2:0]  CRC_T2   = 3'd3;
    localparam logic [2:0]  CRC_DE0D = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_LATCH,
        ST_RAW,
        ST_PAD,
        ST_TRL
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/daq_layer_slicer.sv
// daq_layer_slicer
//   Combinational selector: picks one layer out of the latched time bin and
//   returns DW-bit slice number slice_sel of it. The top slice is
//   zero-extended when LY_W is not a multiple of DW.
// Ports:
//   layer_data  in   NLY*LY_W  latched time bin, layer k = [k*LY_W +: LY_W]
//   layer_sel   in   LYI_W     layer index
//   slice_sel   in   SLI_W     slice index within the layer
//   slice       out  DW        selected slice

module daq_layer_slicer #(
    parameter int NLY   = 6,
    parameter int LY_W  = 112,
    parameter int DW    = 12,
    parameter int NW    = (LY_W + DW - 1) / DW,
    parameter int LYI_W = (NLY > 1) ? $clog2(NLY) : 1,
    parameter int SLI_W = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic [NLY*LY_W-1:0] layer_data,
    input  logic [LYI_W-1:0]    layer_sel,
    input  logic [SLI_W-1:0]    slice_sel,
    output logic [DW-1:0]       slice
);

    logic [LY_W-1:0]  layer_bits;
    logic [NW*DW-1:0] padded;

    // Constant-index loops keep every part-select in range for any NLY/NW
    always_comb begin
        layer_bits = '0;
        for (int k = 0; k < NLY; k++) begin
            if (layer_sel == LYI_W'(k)) begin
                layer_bits = layer_data[k*LY_W +: LY_W];
            end
        end
        padded = '0;
        padded[LY_W-1:0] = layer_bits;
        slice = '0;
        for (int j = 0; j < NW; j++) begin
            if (slice_sel == SLI_W'(j)) begin
                slice = padded[j*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/daq_frame_builder.sv
// daq_frame_builder
//   Pops L1A event descriptors, reads raw layer hits one time bin at a time
//   and streams a 19-bit DAQ frame: 5 header words, raw payload (with
//   optional per-bin / per-layer zero suppression), pad to a multiple of 4,
//   and 4 trailer words. Output uses valid/ready handshaking.
// Ports:
//   clk, hard_rst            clock, async active-low reset
//   evt_valid/evt_ready      descriptor handshake (evt_ready = pop strobe)
//   evt_bxn, evt_l1a_count   descriptor fields, evt_raw_addr = bin 0 address
//   tbins, zero_suppress     per-event readout settings, sampled at pop
//   mem_addr / mem_data      raw memory read port, data one cycle after addr
//   dout/dout_valid/dout_ready  DAQ word stream
//   crc_ctl                  crcgen control aligned with dout

module daq_frame_builder
    import daq_pkg::*;
#(
    parameter int NLY    = 6,
    parameter int LY_W   = 112,
    parameter int DW     = 12,
    parameter int RAW_AW = 8
) (
    input  logic                clk,
    input  logic                hard_rst,
    input  logic                evt_valid,
    output logic                evt_ready,
    input  logic [11:0]         evt_bxn,
    input  logic [11:0]         evt_l1a_count,
    input  logic [RAW_AW-1:0]   evt_raw_addr,
    input  logic [4:0]          tbins,
    input  logic                zero_suppress,
    output logic [RAW_AW-1:0]   mem_addr,
    input  logic [NLY*LY_W-1:0] mem_data,
    output logic [18:0]         dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [2:0]          crc_ctl
);

    localparam int NW    = ceil_div(LY_W, DW);
    localparam int LYI_W = (NLY > 1) ? $clog2(NLY) : 1;
    localparam int SLI_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [4:0] NLY_5 = 5'(NLY);

    state_t              state, state_nxt;
    logic [11:0]         bxn_r, l1a_r, rc_r;
    logic [RAW_AW-1:0]   base_r;
    logic [4:0]          tbins_r, bin_r;
    logic                zs_r;
    logic [LYI_W-1:0]    layer_r;
    logic [SLI_W-1:0]    slice_r;
    logic [10:0]         n_r;
    logic [1:0]          trl_r;
    logic [NLY*LY_W-1:0] layers_r;

    logic                xfer;
    logic [10:0]         n_inc;
    logic [4:0]          bin_inc;
    logic [NLY-1:0]      ly_zero;
    logic                bin_zero, cur_ly_zero;
    logic                last_layer, last_slice, layer_done, bin_end;
    logic [DW-1:0]       slice_w;
    logic [18:0]         raw_word;
    state_t              pad_or_trl;

    daq_layer_slicer #(
        .NLY   (NLY),
        .LY_W  (LY_W),
        .DW    (DW),
        .NW    (NW),
        .LYI_W (LYI_W),
        .SLI_W (SLI_W)
    ) u_slicer (
        .layer_data (layers_r),
        .layer_sel  (layer_r),
        .slice_sel  (slice_r),
        .slice      (slice_w)
    );

    assign xfer     = dout_valid & dout_ready;
    assign n_inc    = n_r + 11'd1;
    assign bin_inc  = bin_r + 5'd1;
    assign mem_addr = base_r + RAW_AW'(bin_r);

    // Zero flags of the latched bin and of the layer currently being read out
    always_comb begin
        ly_zero     = '0;
        cur_ly_zero = 1'b0;
        for (int k = 0; k < NLY; k++) begin
            ly_zero[k] = (layers_r[k*LY_W +: LY_W] == '0);
            if (layer_r == LYI_W'(k)) begin
                cur_ly_zero = (layers_r[k*LY_W +: LY_W] == '0);
            end
        end
        bin_zero = &ly_zero;
        raw_word = '0;
        raw_word[DW-1:0] = slice_w;
    end

    assign last_layer = (layer_r == LYI_W'(NLY - 1));
    assign last_slice = (slice_r == SLI_W'(NW - 1));
    assign layer_done = (zs_r & cur_ly_zero) | last_slice;
    assign bin_end    = (zs_r & bin_zero) | (last_layer & layer_done);
    // The word being transferred decides whether padding is still needed,
    // so an already aligned frame goes straight to the trailer
    assign pad_or_trl = (n_inc[1:0] == 2'b00) ? ST_TRL : ST_PAD;

    // Next state and the output word for the current state
    always_comb begin
        state_nxt  = state;
        dout       = IDLE_WORD;
        dout_valid = 1'b0;
        crc_ctl    = CRC_OFF;
        evt_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (evt_valid) begin
                    evt_ready = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                dout_valid = 1'b1;
                crc_ctl    = CRC_BODY;
                case (n_r[2:0])
                    3'd0:    dout = HDR_MARKER;
                    3'd1:    dout = {HDR_TAG, bxn_r};
                    3'd2:    dout = {HDR_TAG, l1a_r};
                    3'd3:    dout = {HDR_TAG, rc_r};
                    default: dout = {FMT_TAG, zs_r, 1'b0, NLY_5, tbins_r};
                endcase
                if (xfer && n_r[2:0] == 3'd4) begin
                    state_nxt = (tbins_r != 5'd0) ? ST_FETCH : pad_or_trl;
                end
            end
            ST_FETCH: state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_RAW;
            ST_RAW: begin
                dout_valid = 1'b1;
                crc_ctl    = CRC_BODY;
                if (zs_r && bin_zero) begin
                    dout = TBZ_WORD;
                end else if (zs_r && cur_ly_zero) begin
                    dout = LYZ_WORD;
                end else begin
                    dout = raw_word;
                end
                if (xfer && bin_end) begin
                    state_nxt = (bin_inc == tbins_r) ? pad_or_trl : ST_FETCH;
                end
            end
            ST_PAD: begin
                dout_valid = 1'b1;
                crc_ctl    = CRC_BODY;
                dout       = PAD_WORD;
                if (xfer && n_inc[1:0] == 2'b00) begin
                    state_nxt = ST_TRL;
                end
            end
            ST_TRL: begin
                dout_valid = 1'b1;
                case (trl_r)
                    2'd0: begin dout = TRL_MARKER; crc_ctl = CRC_DE0D; end
                    2'd1: begin dout = 19'h0;      crc_ctl = CRC_T1;   end
                    2'd2: begin dout = 19'h0;      crc_ctl = CRC_T2;   end
                    default: begin dout = {TRL_TAG, n_r}; crc_ctl = CRC_OFF; end
                endcase
                if (xfer && trl_r == 2'd3) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, descriptor capture, bin latch and readout counters
    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            state    <= ST_IDLE;
            bxn_r    <= '0;
            l1a_r    <= '0;
            rc_r     <= '0;
            base_r   <= '0;
            tbins_r  <= '0;
            zs_r     <= 1'b0;
            bin_r    <= '0;
            layer_r  <= '0;
            slice_r  <= '0;
            n_r      <= '0;
            trl_r    <= '0;
            layers_r <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                n_r <= n_inc;
            end
            case (state)
                ST_IDLE: begin
                    if (evt_valid) begin
                        bxn_r   <= evt_bxn;
                        l1a_r   <= evt_l1a_count;
                        base_r  <= evt_raw_addr;
                        tbins_r <= tbins;
                        zs_r    <= zero_suppress;
                        n_r     <= '0;
                        bin_r   <= '0;
                        layer_r <= '0;
                        slice_r <= '0;
                        trl_r   <= '0;
                    end
                end
                ST_LATCH: layers_r <= mem_data;
                ST_RAW: begin
                    if (xfer) begin
                        if (bin_end) begin
                            bin_r   <= bin_inc;
                            layer_r <= '0;
                            slice_r <= '0;
                        end else if (layer_done) begin
                            layer_r <= layer_r + LYI_W'(1);
                            slice_r <= '0;
                        end else begin
                            slice_r <= slice_r + SLI_W'(1);
                        end
                    end
                end
                ST_TRL: begin
                    if (xfer) begin
                        trl_r <= trl_r + 2'd1;
                        if (trl_r == 2'd3) begin
                            rc_r <= rc_r + 12'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_daq_frame_builder.sv
// tb_daq_frame_builder
//   Self-checking bench for daq_frame_builder: a table of frame vectors with
//   hand-computed word counts, trailer words and readout counts, a reference
//   stream built from the memory contents, and hand-written sequences for
//   reset, async abort, back-to-back pops and address wrap.

module tb_daq_frame_builder;

    localparam int NLY    = 6;
    localparam int LY_W   = 112;
    localparam int DW     = 12;
    localparam int NW     = 10;
    localparam int RAW_AW = 8;

    logic                clk;
    logic                hard_rst;
    logic                evt_valid;
    logic                evt_ready;
    logic [11:0]         evt_bxn;
    logic [11:0]         evt_l1a_count;
    logic [RAW_AW-1:0]   evt_raw_addr;
    logic [4:0]          tbins;
    logic                zero_suppress;
    logic [RAW_AW-1:0]   mem_addr;
    logic [NLY*LY_W-1:0] mem_data;
    logic [18:0]         dout;
    logic                dout_valid;
    logic                dout_ready;
    logic [2:0]          crc_ctl;

    logic [NLY*LY_W-1:0] mem [0:255];
    logic [21:0]         got[$];
    logic [21:0]         exp_q[$];
    int                  tests;
    int                  failures;
    logic                saw_ff, saw_wrap;

    typedef struct {
        int          tb;
        logic        zs;
        logic [7:0]  base;
        logic [11:0] bxn;
        logic [11:0] l1a;
        int          stall;
        int          exp_count;
        logic [18:0] exp_last;
        logic [11:0] exp_w3;
    } vec_t;

    vec_t tbl[4];

    daq_frame_builder #(
        .NLY    (NLY),
        .LY_W   (LY_W),
        .DW     (DW),
        .RAW_AW (RAW_AW)
    ) dut (
        .clk           (clk),
        .hard_rst      (hard_rst),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_bxn       (evt_bxn),
        .evt_l1a_count (evt_l1a_count),
        .evt_raw_addr  (evt_raw_addr),
        .tbins         (tbins),
        .zero_suppress (zero_suppress),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .crc_ctl       (crc_ctl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raw memory model: registered read, data one cycle after the address
    always @(posedge clk) mem_data <= mem[mem_addr];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NLY*LY_W-1:0] rand_row();
        logic [NLY*LY_W-1:0] r;
        for (int i = 0; i < (NLY*LY_W)/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference stream {crc_ctl, dout} derived from the memory contents
    task automatic build_expected(input int tb, input logic zs, input logic [7:0] base,
                                  input logic [11:0] bxn, input logic [11:0] l1a,
                                  input logic [11:0] rc);
        logic [NLY*LY_W-1:0] row;
        logic [LY_W-1:0]     ly;
        logic [LY_W-1:0]     sh;
        logic [7:0]          a;
        logic [10:0]         idx;
        logic [4:0]          tb5;
        tb5 = 5'(tb);
        exp_q.delete();
        exp_q.push_back({3'd1, 19'h0DB0A});
        exp_q.push_back({3'd1, 7'h0D, bxn});
        exp_q.push_back({3'd1, 7'h0D, l1a});
        exp_q.push_back({3'd1, 7'h0D, rc});
        exp_q.push_back({3'd1, 7'h00, zs, 1'b0, 5'd6, tb5});
        for (int b = 0; b < tb; b++) begin
            a = base + 8'(b);
            row = mem[a];
            if (zs && row == '0) begin
                exp_q.push_back({3'd1, 19'h02000});
            end else begin
                for (int k = 0; k < NLY; k++) begin
                    ly = row[k*LY_W +: LY_W];
                    if (zs && ly == '0) begin
                        exp_q.push_back({3'd1, 19'h01000});
                    end else begin
                        for (int j = 0; j < NW; j++) begin
                            sh = ly >> (j*DW);
                            exp_q.push_back({3'd1, 7'h00, sh[11:0]});
                        end
                    end
                end
            end
        end
        while (exp_q.size() % 4 != 0) exp_q.push_back({3'd1, 19'h03000});
        exp_q.push_back({3'd4, 19'h0DE0D});
        exp_q.push_back({3'd2, 19'h00000});
        exp_q.push_back({3'd3, 19'h00000});
        idx = 11'(exp_q.size());
        exp_q.push_back({3'd0, 8'h3A, idx});
    endtask

    // Drive one descriptor and collect its frame; optional mid-RAW and
    // trailer stalls of 3 cycles each
    task automatic apply_stimulus(input vec_t v, input logic [11:0] rc, input int keep, input string tag);
        int          pops = 0;
        int          stall_left = 0;
        int          stalls_seen = 0;
        int          first_bad = -1;
        logic        popped = 1'b0;
        logic        hold_first = 1'b1;
        logic        hold_bad = 1'b0;
        logic [21:0] held = '0;
        logic [21:0] held_trl = '0;
        build_expected(v.tb, v.zs, v.base, v.bxn, v.l1a, rc);
        got.delete();
        evt_bxn       = v.bxn;
        evt_l1a_count = v.l1a;
        evt_raw_addr  = v.base;
        tbins         = 5'(v.tb);
        zero_suppress = v.zs;
        evt_valid     = 1'b1;
        dout_ready    = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (evt_ready) begin
                pops++;
                popped = 1'b1;
            end
            if (dout_valid && dout_ready) got.push_back({crc_ctl, dout});
            if (mem_addr == 8'hFF) saw_ff = 1'b1;
            else if (mem_addr == 8'h00 && saw_ff) saw_wrap = 1'b1;
            if (!dout_ready) begin
                if (hold_first) begin
                    held = {crc_ctl, dout};
                    hold_first = 1'b0;
                    stalls_seen++;
                    if (stalls_seen == 2) held_trl = held;
                    if (!dout_valid) hold_bad = 1'b1;
                end else if ({crc_ctl, dout} != held || !dout_valid) begin
                    hold_bad = 1'b1;
                end
            end else begin
                hold_first = 1'b1;
            end
            if (v.stall != 0 && dout_valid && dout_ready && (got.size() == 30 || got.size() == 68))
                stall_left = 3;
            if (got.size() >= v.exp_count) break;
            @(posedge clk);
            #1;
            if (popped && keep == 0) evt_valid = 1'b0;
            if (stall_left > 0) begin
                dout_ready = 1'b0;
                stall_left--;
            end else begin
                dout_ready = 1'b1;
            end
        end
        check_output({tag, "_word_count"}, got.size(), v.exp_count);
        check_output({tag, "_pops"}, pops, 1);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (first_bad < 0 && got[i] !== exp_q[i]) first_bad = i;
        end
        tests++;
        if (first_bad >= 0 || got.size() != exp_q.size()) begin
            failures++;
            if (first_bad >= 0)
                $display("[TB] FAIL %s_stream word %0d: got %h expected %h", tag, first_bad, got[first_bad], exp_q[first_bad]);
            else
                $display("[TB] FAIL %s_stream length: got %0d expected %0d", tag, got.size(), exp_q.size());
        end
        if (got.size() > 4) begin
            check_output({tag, "_last"}, {13'h0, got[got.size()-1][18:0]}, {13'h0, v.exp_last});
            check_output({tag, "_w3_rc"}, {20'h0, got[3][11:0]}, {20'h0, v.exp_w3});
        end else begin
            check_output({tag, "_short_frame"}, got.size(), v.exp_count);
        end
        if (v.stall != 0) begin
            check_output({tag, "_stalls"}, stalls_seen, 2);
            check_output({tag, "_hold_stable"}, {31'h0, hold_bad}, 0);
            check_output({tag, "_held_de0d"}, {10'h0, held_trl}, {10'h0, 3'd4, 19'h0DE0D});
        end
    endtask

    initial begin
        logic [NLY*LY_W-1:0] row;
        logic [LY_W-1:0]     lyr;
        int                  cnt;
        logic                popped;
        vec_t                v6;

        tests = 0;
        failures = 0;
        saw_ff = 1'b0;
        saw_wrap = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h20] = rand_row();
        mem[8'h40] = '0;
        lyr = 112'({$urandom, $urandom, $urandom, $urandom}) | 112'd1;
        row = '0;
        row[2*LY_W +: LY_W] = lyr;
        mem[8'h41] = row;
        mem[8'hFF] = rand_row();
        mem[8'h00] = rand_row();

        tbl[0] = '{tb: 0, zs: 1'b0, base: 8'h10, bxn: 12'hABC, l1a: 12'h123, stall: 0,
                   exp_count: 12, exp_last: 19'h1D00B, exp_w3: 12'h000};
        tbl[1] = '{tb: 1, zs: 1'b0, base: 8'h20, bxn: 12'h055, l1a: 12'h7FE, stall: 0,
                   exp_count: 72, exp_last: 19'h1D047, exp_w3: 12'h001};
        tbl[2] = '{tb: 2, zs: 1'b1, base: 8'h40, bxn: 12'hFFF, l1a: 12'h000, stall: 0,
                   exp_count: 28, exp_last: 19'h1D01B, exp_w3: 12'h002};
        tbl[3] = '{tb: 1, zs: 1'b0, base: 8'h20, bxn: 12'h055, l1a: 12'h7FE, stall: 1,
                   exp_count: 72, exp_last: 19'h1D047, exp_w3: 12'h003};

        hard_rst      = 1'b1;
        evt_valid     = 1'b0;
        evt_bxn       = '0;
        evt_l1a_count = '0;
        evt_raw_addr  = '0;
        tbins         = '0;
        zero_suppress = 1'b0;
        dout_ready    = 1'b1;
        #2 hard_rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_dout", {13'h0, dout}, {13'h0, 19'h40000});
        check_output("rst_valid", {31'h0, dout_valid}, 0);
        check_output("rst_evt_ready", {31'h0, evt_ready}, 0);
        check_output("rst_crc", {29'h0, crc_ctl}, 0);
        check_output("rst_mem_addr", {24'h0, mem_addr}, 0);
        #2 hard_rst = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 4; t++) begin
            apply_stimulus(tbl[t], tbl[t].exp_w3, 0, $sformatf("vec%0d", t));
        end

        // Reset asserted in the middle of the raw payload aborts at once
        evt_bxn       = 12'h055;
        evt_l1a_count = 12'h7FE;
        evt_raw_addr  = 8'h20;
        tbins         = 5'd1;
        zero_suppress = 1'b0;
        evt_valid     = 1'b1;
        dout_ready    = 1'b1;
        cnt = 0;
        popped = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            if (evt_ready) popped = 1'b1;
            if (dout_valid && dout_ready) cnt++;
            if (cnt == 20) break;
            @(posedge clk);
            #1;
            if (popped) evt_valid = 1'b0;
        end
        evt_valid = 1'b0;
        check_output("abort_reached_raw", cnt, 20);
        check_output("abort_pre_valid", {31'h0, dout_valid}, 1);
        #2 hard_rst = 1'b0;
        #1;
        check_output("abort_dout", {13'h0, dout}, {13'h0, 19'h40000});
        check_output("abort_valid", {31'h0, dout_valid}, 0);
        check_output("abort_crc", {29'h0, crc_ctl}, 0);
        @(negedge clk);
        #2 hard_rst = 1'b1;
        @(posedge clk);
        #1;

        // Two queued events with evt_valid held high, bins wrapping FF -> 00
        v6 = '{tb: 2, zs: 1'b0, base: 8'hFF, bxn: 12'h321, l1a: 12'h456, stall: 0,
               exp_count: 132, exp_last: 19'h1D083, exp_w3: 12'h000};
        saw_ff = 1'b0;
        saw_wrap = 1'b0;
        apply_stimulus(v6, 12'h000, 1, "b2b_first");
        check_output("addr_wrap", {31'h0, saw_wrap}, 1);
        v6.exp_w3 = 12'h001;
        apply_stimulus(v6, 12'h001, 0, "b2b_second");

        repeat (3) @(negedge clk);
        check_output("end_idle_valid", {31'h0, dout_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
